// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous SRAM controller for the external RAM port.
//
// Each 32-bit request is served as two 16-bit SRAM phases, LO (half-word
// address bit 0 = 0) and HI (bit 0 = 1). A one-cycle GAP with all strobes
// released sits between them. Each phase lasts wait_states+1 cycles.
// Requests whose address lies above the SRAM window complete at once with
// mem_error set, and no SRAM strobe is issued. Every output is registered.
//
// Optional feature: define SRAM_CTRL_SKIP_EN to skip write phases whose byte
// strobe pair is zero. The GAP cycle is then omitted as well. Reads always
// run both phases.
//
// Parameters:
//   wait_states - extra cycles per SRAM phase (>= 1)
//   addr_width  - SRAM half-word address width
// Ports:
//   clock                    - single clock
//   reset                    - asynchronous active-low reset
//   sram_in                  - request (valid strobe, address, wdata, wstrb)
//   sram_out                 - response (ready, error, rdata)
//   sram_addr                - SRAM half-word address
//   sram_dq_o / sram_dq_i    - SRAM data out / in
//   sram_dq_oe               - data bus drive enable
//   sram_ce_n/oe_n/we_n      - chip, output and write enables (active low)
//   sram_lb_n/ub_n           - byte enables for dq[7:0] / dq[15:8] (active low)

package sram_ctrl_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int wait_states = 2,
    parameter int addr_width  = 18
) (
    input  logic                  clock,
    input  logic                  reset,
    input  mem_in_type            sram_in,
    output mem_out_type           sram_out,
    output logic [addr_width-1:0] sram_addr,
    output logic [15:0]           sram_dq_o,
    input  logic [15:0]           sram_dq_i,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_lb_n,
    output logic                  sram_ub_n
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam int            CW   = (wait_states < 2) ? 1 : $clog2(wait_states + 1);
    localparam logic [CW-1:0] LAST = CW'(wait_states);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [addr_width-2:0] base_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  write_q;

    logic [addr_width-1:0] addr_q, addr_d;
    logic [15:0]           dq_o_q, dq_o_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic                  lb_n_q, lb_n_d;
    logic                  ub_n_q, ub_n_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  idle;
    logic                  accept;
    logic                  out_of_range;
    logic [addr_width-2:0] req_base;
    logic [31:0]           req_wdata;
    logic [3:0]            req_wstrb;
    logic                  req_write;
    logic                  phase_hi;
    logic                  unused_bits;

    assign idle         = (state_q == S_IDLE);
    assign accept       = idle && sram_in.mem_valid;
    assign out_of_range = |sram_in.mem_addr[31:addr_width+1];

    // In the accept cycle the latches are not yet loaded, so the first phase
    // setup has to come straight from the request bus.
    assign req_base  = idle ? sram_in.mem_addr[addr_width:2] : base_q;
    assign req_wdata = idle ? sram_in.mem_wdata : wdata_q;
    assign req_wstrb = idle ? sram_in.mem_wstrb : wstrb_q;
    assign req_write = idle ? (|sram_in.mem_wstrb) : write_q;

    assign unused_bits = ^{sram_in.mem_instr, sram_in.mem_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (sram_in.mem_valid) begin
                    cnt_d = '0;
                    if (out_of_range) begin
                        state_d = S_RESP;
                    end else begin
`ifdef SRAM_CTRL_SKIP_EN
                        if ((sram_in.mem_wstrb[3:2] != 2'b00) && (sram_in.mem_wstrb[1:0] == 2'b00)) begin
                            state_d = S_HI;
                        end else begin
                            state_d = S_LO;
                        end
`else
                        state_d = S_LO;
`endif
                    end
                end
            end
            S_LO: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef SRAM_CTRL_SKIP_EN
                    if (write_q && (wstrb_q[3:2] == 2'b00)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_GAP;
                    end
`else
                    state_d = S_GAP;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                cnt_d   = '0;
                state_d = S_HI;
            end
            S_HI: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so that they appear registered
    // in the very cycle the FSM enters that state. sram_addr and dq_o hold
    // their values outside the phases.
    always_comb begin
        addr_d   = addr_q;
        dq_o_d   = dq_o_q;
        dq_oe_d  = 1'b0;
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        ready_d  = (state_d == S_RESP);
        error_d  = error_q;
        rdata_d  = rdata_q;
        phase_hi = (state_d == S_HI);

        if (accept) begin
            error_d = out_of_range;
            rdata_d = '0;
        end

        // Read data is taken only on the last cycle of a phase, when the
        // SRAM access time has fully elapsed.
        if (!write_q && (cnt_q == LAST)) begin
            if (state_q == S_LO) begin
                rdata_d[15:0] = sram_dq_i;
            end
            if (state_q == S_HI) begin
                rdata_d[31:16] = sram_dq_i;
            end
        end

        if ((state_d == S_LO) || (state_d == S_HI)) begin
            addr_d = {req_base, phase_hi};
            ce_n_d = 1'b0;
            if (req_write) begin
                dq_oe_d = 1'b1;
                dq_o_d  = phase_hi ? req_wdata[31:16] : req_wdata[15:0];
                lb_n_d  = phase_hi ? ~req_wstrb[2] : ~req_wstrb[0];
                ub_n_d  = phase_hi ? ~req_wstrb[3] : ~req_wstrb[1];
                // The final phase cycle releases we_n while data is still
                // driven, giving the SRAM its data hold time.
                we_n_d  = (cnt_d == LAST);
            end else begin
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
            if (accept) begin
                base_q  <= sram_in.mem_addr[addr_width:2];
                wdata_q <= sram_in.mem_wdata;
                wstrb_q <= sram_in.mem_wstrb;
                write_q <= |sram_in.mem_wstrb;
            end
        end
    end

    assign sram_addr          = addr_q;
    assign sram_dq_o          = dq_o_q;
    assign sram_dq_oe         = dq_oe_q;
    assign sram_ce_n          = ce_n_q;
    assign sram_oe_n          = oe_n_q;
    assign sram_we_n          = we_n_q;
    assign sram_lb_n          = lb_n_q;
    assign sram_ub_n          = ub_n_q;
    assign sram_out.mem_ready = ready_q;
    assign sram_out.mem_error = error_q;
    assign sram_out.mem_rdata = rdata_q;

endmodule
